// File: rtl/store_buffer_pkg.sv
// Shared CPU-side definitions for the store buffer and future cache work.
package store_buffer_pkg;

    localparam int WORD_W   = 32;
    localparam int WADDR_HI = 31;
    localparam int WADDR_LO = 2;
    localparam int WADDR_W  = WADDR_HI - WADDR_LO + 1;

    // One buffered store: word address plus full-word data (no byte enables).
    typedef struct packed {
        logic [WADDR_W-1:0] addr;
        logic [WORD_W-1:0]  data;
    } sb_entry_t;

    // Word address of a byte address; the low two bits are ignored.
    function automatic logic [WADDR_W-1:0] word_addr(input logic [WORD_W-1:0] byte_addr);
        return byte_addr[WADDR_HI:WADDR_LO];
    endfunction

endpackage

// File: rtl/store_buffer_match.sv
// Youngest-match priority search over the valid store-buffer entries.
module store_buffer_match
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  sb_entry_t [DEPTH-1:0] entries,
    input  logic [PTR_W-1:0]      head,
    input  logic [PTR_W:0]        count,
    input  logic [WADDR_W-1:0]    addr,
    output logic                  hit,
    output logic [WORD_W-1:0]     data
);

    logic [PTR_W-1:0] idx;

    // Walk oldest to youngest; a later (younger) match overrides earlier ones.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if (((PTR_W+1)'(i) < count) && (entries[idx].addr == addr)) begin
                hit  = 1'b1;
                data = entries[idx].data;
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Store FIFO between the CPU MEM stage and a slow req/ack memory write port,
// with same-cycle forwarding of buffered stores to loads.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic [WORD_W-1:0] cpu_addr,
    input  logic [WORD_W-1:0] cpu_wdata,
    input  logic              cpu_wmem,
    output logic [WORD_W-1:0] cpu_rdata,
    output logic              stall,
    output logic [WORD_W-1:0] rd_addr,
    input  logic [WORD_W-1:0] rd_data,
    output logic              wr_req,
    output logic [WORD_W-1:0] wr_addr,
    output logic [WORD_W-1:0] wr_data,
    input  logic              wr_ack,
    output logic              empty
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    sb_entry_t [DEPTH-1:0] entries;
    logic [PTR_W-1:0]      head;
    logic [PTR_W-1:0]      tail;
    logic [PTR_W:0]        count;

    logic              full;
    logic              enq;
    logic              deq;
    logic              fwd_hit;
    logic [WORD_W-1:0] fwd_data;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

    // Stall is a function of occupancy only, so a full buffer being acked this
    // cycle still stalls; the store is taken on the following edge.
    assign stall = cpu_wmem & full;
    assign enq   = cpu_wmem & ~full;
    assign deq   = wr_ack & ~empty;

    // Head/tail/count; reset drops every pending store, so wr_req falls at once.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq) tail <= tail + 1'b1;
            if (deq) head <= head + 1'b1;
            case ({enq, deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage; contents are don't-care until made valid by count.
    always_ff @(posedge clock) begin
        if (enq) entries[tail] <= '{addr: word_addr(cpu_addr), data: cpu_wdata};
    end

    // Head entry is presented until the ack edge, which keeps it stable.
    assign wr_req  = ~empty;
    assign wr_addr = {entries[head].addr, 2'b00};
    assign wr_data = entries[head].data;

    // The store presented this cycle is not yet in entries, so it is never
    // forwarded to itself; an entry being acked this cycle still matches.
    store_buffer_match #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_match (
        .entries (entries),
        .head    (head),
        .count   (count),
        .addr    (word_addr(cpu_addr)),
        .hit     (fwd_hit),
        .data    (fwd_data)
    );

    assign rd_addr   = cpu_addr;
    assign cpu_rdata = fwd_hit ? fwd_data : rd_data;

endmodule
